// File: rtl/fifo_get_serializer.sv
// Get-side FIFO consumer: prefetches one word into a holding register and shifts
// it out MSB-first on a framed serial link, inserting zero words on underrun.
module fifo_get_serializer #(
   parameter int DATA_WIDTH = 32,
   parameter int BIT_DIV    = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk_get,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  empty_out,
   input  logic [DATA_WIDTH-1:0] data_get,
   output logic                  req_get,
   output logic                  ser_clk,
   output logic                  ser_data,
   output logic                  ser_frame,
   output logic                  busy,
   output logic                  underrun,
   input  logic                  underrun_clr,
   output logic [CNT_WIDTH-1:0]  words_sent
);

   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam int DIV_W = $clog2(BIT_DIV);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BIT_DIV / 2);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t                state_r, state_s;
   logic [DATA_WIDTH-1:0] shift_r, shift_s;
   logic [IDX_W-1:0]      bit_idx_r, bit_idx_s;
   logic [DIV_W-1:0]      div_cnt_r, div_cnt_s;
   logic [DATA_WIDTH-1:0] hold_r;
   logic                  hold_valid_r;
   logic                  req_r;
   logic                  pend_r;
   logic                  fetch_s;
   logic                  load_hold_s;
   logic                  load_zero_s;
   logic                  underrun_r;
   logic [CNT_WIDTH-1:0]  words_sent_r;
   logic                  ser_clk_r, ser_data_r, ser_frame_r, busy_r;

   // Fetch decision: one request at a time, only into an empty hold register.
   always_comb begin
      fetch_s = 1'b0;
      if (!hold_valid_r && !req_r && !pend_r && enable && !empty_out) begin
         fetch_s = 1'b1;
      end else begin
         fetch_s = 1'b0;
      end
   end

   // Shifter next-state: bit timing, word reload and underrun insertion.
   always_comb begin
      state_s     = state_r;
      shift_s     = shift_r;
      bit_idx_s   = bit_idx_r;
      div_cnt_s   = div_cnt_r;
      load_hold_s = 1'b0;
      load_zero_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (enable && hold_valid_r) begin
               state_s     = ST_SHIFT;
               shift_s     = hold_r;
               bit_idx_s   = '0;
               div_cnt_s   = '0;
               load_hold_s = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (div_cnt_r != DIV_LAST) begin
               div_cnt_s = div_cnt_r + 1'b1;
            end else if (bit_idx_r != IDX_LAST) begin
               div_cnt_s = '0;
               bit_idx_s = bit_idx_r + 1'b1;
               shift_s   = {shift_r[DATA_WIDTH-2:0], 1'b0};
            end else if (enable && hold_valid_r) begin
               div_cnt_s   = '0;
               bit_idx_s   = '0;
               shift_s     = hold_r;
               load_hold_s = 1'b1;
            end else if (enable) begin
               // Hold ran dry at a word boundary: keep the link framed with a zero word.
               div_cnt_s   = '0;
               bit_idx_s   = '0;
               shift_s     = '0;
               load_zero_s = 1'b1;
            end else begin
               state_s   = ST_IDLE;
               div_cnt_s = '0;
               bit_idx_s = '0;
               shift_s   = '0;
            end
         end
         default: begin
            state_s   = ST_IDLE;
            shift_s   = '0;
            bit_idx_s = '0;
            div_cnt_s = '0;
         end
      endcase
   end

   // Request pulse, outstanding-read tracking and holding register.
   always_ff @(posedge clk_get or negedge reset) begin
      if (!reset) begin
         req_r        <= 1'b0;
         pend_r       <= 1'b0;
         hold_r       <= '0;
         hold_valid_r <= 1'b0;
      end else begin
         req_r  <= fetch_s;
         pend_r <= req_r;
         if (pend_r) begin
            hold_r       <= data_get;
            hold_valid_r <= 1'b1;
         end else if (load_hold_s) begin
            hold_valid_r <= 1'b0;
         end
      end
   end

   // Shifter state, counters and registered serial outputs.
   always_ff @(posedge clk_get or negedge reset) begin
      if (!reset) begin
         state_r      <= ST_IDLE;
         shift_r      <= '0;
         bit_idx_r    <= '0;
         div_cnt_r    <= '0;
         underrun_r   <= 1'b0;
         words_sent_r <= '0;
         ser_clk_r    <= 1'b0;
         ser_data_r   <= 1'b0;
         ser_frame_r  <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         state_r   <= state_s;
         shift_r   <= shift_s;
         bit_idx_r <= bit_idx_s;
         div_cnt_r <= div_cnt_s;
         if (load_zero_s) begin
            underrun_r <= 1'b1;
         end else if (underrun_clr) begin
            underrun_r <= 1'b0;
         end
         if (load_hold_s) begin
            words_sent_r <= words_sent_r + 1'b1;
         end
         ser_data_r  <= (state_s == ST_SHIFT) && shift_s[DATA_WIDTH-1];
         ser_clk_r   <= (state_s == ST_SHIFT) && (div_cnt_s >= DIV_HALF);
         ser_frame_r <= (state_s == ST_SHIFT) && (bit_idx_s == '0);
         busy_r      <= (state_s == ST_SHIFT);
      end
   end

   assign req_get    = req_r;
   assign ser_clk    = ser_clk_r;
   assign ser_data   = ser_data_r;
   assign ser_frame  = ser_frame_r;
   assign busy       = busy_r;
   assign underrun   = underrun_r;
   assign words_sent = words_sent_r;

endmodule

// File: tb/tb_fifo_get_serializer.sv
// Directed bench for fifo_get_serializer: a queue stands in for the FIFO and
// every serial word is rebuilt from ser_data and compared with the pushed value.
module tb_fifo_get_serializer;

   localparam int DW       = 32;
   localparam int BD       = 4;
   localparam int CW       = 16;
   localparam int WORD_CYC = DW * BD;

   logic          clk_get = 1'b0;
   logic          reset;
   logic          enable;
   logic          empty_out;
   logic [DW-1:0] data_get;
   logic          req_get;
   logic          ser_clk;
   logic          ser_data;
   logic          ser_frame;
   logic          busy;
   logic          underrun;
   logic          underrun_clr;
   logic [CW-1:0] words_sent;

   int          vec_cnt  = 0;
   int          miss_cnt = 0;
   int          req_cnt  = 0;
   logic        req_prev = 1'b0;
   logic [31:0] fifo_q[$];
   int          waited;
   int          errs3;

   fifo_get_serializer #(.DATA_WIDTH(DW), .BIT_DIV(BD), .CNT_WIDTH(CW)) dut (
      .clk_get     (clk_get),
      .reset       (reset),
      .enable      (enable),
      .empty_out   (empty_out),
      .data_get    (data_get),
      .req_get     (req_get),
      .ser_clk     (ser_clk),
      .ser_data    (ser_data),
      .ser_frame   (ser_frame),
      .busy        (busy),
      .underrun    (underrun),
      .underrun_clr(underrun_clr),
      .words_sent  (words_sent)
   );

   always #5 clk_get = ~clk_get;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // One clock; a request seen in the previous cycle pops the FIFO model.
   task automatic tick();
      @(posedge clk_get);
      #1;
      if (req_prev) begin
         if (fifo_q.size() > 0) data_get = fifo_q.pop_front();
         else data_get = 32'hDEAD_BEEF;
      end
      empty_out = (fifo_q.size() == 0);
      req_prev  = req_get;
      if (req_get) req_cnt++;
   endtask

   task automatic push(input logic [31:0] w);
      fifo_q.push_back(w);
      empty_out = 1'b0;
   endtask

   task automatic do_reset();
      reset        = 1'b0;
      enable       = 1'b0;
      underrun_clr = 1'b0;
      fifo_q.delete();
      empty_out    = 1'b1;
      data_get     = '0;
      req_prev     = 1'b0;
      repeat (2) tick();
      reset   = 1'b1;
      req_cnt = 0;
      tick();
   endtask

   task automatic wait_frame(input int budget, output int n);
      n = 0;
      while (ser_frame !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
   endtask

   // Called in the first cycle of a frame; consumes exactly one word period.
   task automatic recv_word(input logic [31:0] exp, input string tag, input int drop_at, input int clr_at);
      logic [31:0] w;
      int          errs;
      w    = '0;
      errs = 0;
      for (int c = 0; c < WORD_CYC; c++) begin
         int b;
         int d;
         b = c / BD;
         d = c % BD;
         if (d == 0) w = {w[30:0], ser_data};
         else if (ser_data !== w[0]) errs++;
         if (ser_clk !== (d >= BD / 2)) errs++;
         if (ser_frame !== (b == 0)) errs++;
         if (busy !== 1'b1) errs++;
         if (c == drop_at) enable = 1'b0;
         underrun_clr = (c == clr_at);
         tick();
      end
      underrun_clr = 1'b0;
      check_val({tag, "_word"}, w, exp);
      check_val({tag, "_pattern"}, errs, 32'd0);
   endtask

   initial begin
      do_reset();
      check_val("reset_outs", {req_get, ser_clk, ser_data, ser_frame, busy, underrun}, 32'd0);
      check_val("reset_cnt", words_sent, 32'd0);

      // single word, then underrun zero word
      push(32'hA5A5_0F0F);
      enable = 1'b1;
      tick();
      check_val("t1_req_n1", req_get, 32'd1);
      tick();
      check_val("t1_req_pulse", req_get, 32'd0);
      tick();
      check_val("t1_frame_n2", ser_frame, 32'd0);
      tick();
      check_val("t1_frame_n3", ser_frame, 32'd1);
      check_val("t1_cnt", words_sent, 32'd1);
      recv_word(32'hA5A5_0F0F, "t1", -1, -1);
      check_val("t1_zero_frame", ser_frame, 32'd1);
      check_val("t1_underrun", underrun, 32'd1);
      check_val("t1_cnt_keep", words_sent, 32'd1);
      check_val("t1_reqs", req_cnt, 32'd1);
      recv_word(32'h0000_0000, "t1z", 0, -1);
      check_val("t1_idle", {busy, ser_clk, ser_data, ser_frame}, 32'd0);
      push(32'h5555_AAAA);
      underrun_clr = 1'b1;
      tick();
      underrun_clr = 1'b0;
      check_val("t1_clr", underrun, 32'd0);

      // back-to-back words
      do_reset();
      push(32'h0000_0001);
      push(32'h8000_0000);
      push(32'hFFFF_FFFF);
      enable = 1'b1;
      wait_frame(20, waited);
      check_val("t2_latency", waited, 32'd4);
      recv_word(32'h0000_0001, "t2a", -1, -1);
      check_val("t2_gap_a", {ser_frame, underrun}, 32'd2);
      recv_word(32'h8000_0000, "t2b", -1, -1);
      check_val("t2_gap_b", {ser_frame, underrun}, 32'd2);
      recv_word(32'hFFFF_FFFF, "t2c", -1, -1);
      check_val("t2_fourth", {ser_frame, underrun}, 32'd3);
      check_val("t2_cnt", words_sent, 32'd3);
      check_val("t2_reqs", req_cnt, 32'd3);
      recv_word(32'h0000_0000, "t2z", 0, -1);
      check_val("t2_idle", busy, 32'd0);

      // empty FIFO
      do_reset();
      enable = 1'b1;
      errs3  = 0;
      repeat (500) begin
         tick();
         if (req_get || busy || ser_clk || ser_data || ser_frame) errs3++;
      end
      check_val("t3_quiet", errs3, 32'd0);
      check_val("t3_reqs", req_cnt, 32'd0);

      // enable drop mid-word, hold retained
      do_reset();
      push(32'h1234_5678);
      push(32'hCAFE_BABE);
      enable = 1'b1;
      wait_frame(20, waited);
      check_val("t4_latency", waited, 32'd4);
      recv_word(32'h1234_5678, "t4a", 40, -1);
      check_val("t4_idle", {busy, ser_clk, ser_data, ser_frame}, 32'd0);
      check_val("t4_cnt", words_sent, 32'd1);
      repeat (10) tick();
      check_val("t4_still_idle", busy, 32'd0);
      check_val("t4_reqs", req_cnt, 32'd2);
      enable = 1'b1;
      tick();
      check_val("t4_restart", ser_frame, 32'd1);
      recv_word(32'hCAFE_BABE, "t4b", -1, 127);
      check_val("t4_set_wins", underrun, 32'd1);
      check_val("t4_cnt2", words_sent, 32'd2);
      check_val("t4_reqs2", req_cnt, 32'd2);
      recv_word(32'h0000_0000, "t4z", 0, -1);
      check_val("t4_end", busy, 32'd0);

      // asynchronous reset mid-word
      do_reset();
      push(32'h0F0F_0F0F);
      push(32'h1111_1111);
      push(32'h2222_2222);
      enable = 1'b1;
      wait_frame(20, waited);
      check_val("t5_latency", waited, 32'd4);
      repeat (17 * BD + 2) tick();
      check_val("t5_busy", busy, 32'd1);
      reset = 1'b0;
      #1;
      check_val("t5_async", {req_get, ser_clk, ser_data, ser_frame, busy, underrun}, 32'd0);
      check_val("t5_cnt", words_sent, 32'd0);
      tick();
      reset = 1'b1;
      tick();
      check_val("t5_req_n1", {req_get, ser_frame}, 32'd2);
      tick();
      tick();
      tick();
      check_val("t5_frame_n3", ser_frame, 32'd1);
      recv_word(32'h2222_2222, "t5", 0, -1);
      check_val("t5_idle", busy, 32'd0);
      check_val("t5_cnt2", words_sent, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
